// File: rtl/sensor_acq_ctrl_pkg.sv
// Shared types and constants for the sensor acquisition front-end.
// Optional build macro: ACQ_ROUND_EN (round-half-up averaging).
package acq_pkg;

    typedef enum logic [1:0] {
        DISABLED,
        ACCUM,
        WRITE
    } acq_state_e;

    localparam int DROP_CNT_W = 8;

    // Accumulator width: the sum of 2^avg_log2 samples never overflows, and
    // one extra bit absorbs the rounding addend when rounding is built in.
    function automatic int acc_width(input int data_w, input int avg_log2, input bit round_en);
        return data_w + avg_log2 + (round_en ? 1 : 0);
    endfunction

endpackage

// File: rtl/sensor_acq_ctrl_if.sv
// Valid/ready sample stream between the sensor source and the acquisition block.
interface sensor_acq_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              ready;

    // Sample producer side.
    modport master (output valid, output data, input ready);
    // Acquisition block side.
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/sensor_acq_ctrl_hold_timer.sv
// Hold window generator: a host write opens a window of HOLD_CYCLES cycles
// during which sensor writes to the register would be ignored.
module acq_hold_timer #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic host_wr_i,
    output logic hold_o
);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    logic [HOLD_W-1:0] hold_cnt_q;

    // Reload on every host write, otherwise count down to zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_cnt_q <= '0;
        end else if (host_wr_i) begin
            hold_cnt_q <= HOLD_W'(HOLD_CYCLES);
        end else if (hold_cnt_q != '0) begin
            hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
        end
    end

    // Straight from the counter flop: high the cycle after the host write.
    assign hold_o = (hold_cnt_q != '0);

endmodule

// File: rtl/sensor_acq_ctrl.sv
// Sensor acquisition front-end: averages 2^AVG_LOG2 samples, drives the
// control register's sensor write port and hold control, and counts sensor
// writes that land inside a host hold window.
// Optional build macro: ACQ_ROUND_EN (round-half-up instead of floor).
module sensor_acq_ctrl
    import acq_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int AVG_LOG2    = 2,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    sensor_acq_ctrl_if.slave      sample,
    input  logic                  host_wr_i,
    output logic [DATA_W-1:0]     data1_o,
    output logic                  wr1_o,
    output logic                  hold_ctrl_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
);
`ifdef ACQ_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    localparam int ACC_W = acc_width(DATA_W, AVG_LOG2, ROUND_EN);
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int GROUP = 1 << AVG_LOG2;
    // Half an LSB of the averaged result; zero for pass-through.
    localparam logic [ACC_W-1:0] ROUND_ADD = ROUND_EN ? ACC_W'((2 ** AVG_LOG2) / 2) : '0;
    localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

    acq_state_e        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data1_q, data1_d;
    logic [DROP_CNT_W-1:0] drop_q;

    logic [ACC_W-1:0]  sum;
    logic [ACC_W-1:0]  rounded;
    logic              accept;
    logic              last;

    assign sum     = acc_q + ACC_W'(sample.data);
    assign rounded = sum + ROUND_ADD;
    assign accept  = sample.valid && (state_q == ACCUM);
    assign last    = (cnt_q == CNT_W'(GROUP - 1));

    // State, accumulator and output data registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_ni) begin
            state_q <= DISABLED;
            acc_q   <= '0;
            cnt_q   <= '0;
            data1_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            data1_q <= data1_d;
        end
    end

    // Next-state logic: accumulate a group, emit one WRITE cycle, repeat.
    always_comb begin
        // NOTE: every signal driven here is defaulted first so no path infers a latch.
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        data1_d = data1_q;

        unique case (state_q)
            DISABLED: begin
                if (enable_i) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            ACCUM: begin
                if (!enable_i) begin
                    // Partial group is discarded; data1 keeps its last value.
                    state_d = DISABLED;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else if (accept) begin
                    if (last) begin
                        state_d = WRITE;
                        data1_d = DATA_W'(rounded >> AVG_LOG2);
                        acc_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            WRITE: begin
                state_d = enable_i ? ACCUM : DISABLED;
                acc_d   = '0;
                cnt_d   = '0;
            end
            default: begin
                state_d = DISABLED;
                acc_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    acq_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .host_wr_i(host_wr_i),
        .hold_o   (hold_ctrl_o)
    );

    // Count sensor writes the register will ignore because hold is active.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_q <= '0;
        end else if (wr1_o && hold_ctrl_o && (drop_q != DROP_MAX)) begin
            drop_q <= drop_q + DROP_CNT_W'(1);
        end
    end

    assign sample.ready = (state_q == ACCUM);
    assign wr1_o        = (state_q == WRITE);
    assign data1_o      = data1_q;
    assign drop_cnt_o   = drop_q;

endmodule

// File: doc/sensor_acq_ctrl.md
Name: sensor_acq_ctrl

Overview:
Acquisition front-end that sits directly upstream of the control register. It accepts raw sensor samples over a valid/ready handshake and averages 2^AVG_LOG2 samples. It drives the register's sensor write port (data1/wr1) and its hold control. The hold window keeps a fresh host write (wr2) from being overwritten by the next sensor average.

Parameters:
DATA_W, 32, width of each sample and of the averaged output
AVG_LOG2, 2, log2 of the samples per average; 0 = pass-through
HOLD_CYCLES, 4, number of cycles hold_ctrl_o stays high after a host write; must be ≥1

Ports:
clk_i  in  1  clock; all logic on the rising edge
rst_ni  in  1  asynchronous, active-low reset
enable_i  in  1  acquisition enable
sample_valid_i  in  1  sample present
sample_data_i  in  DATA_W  unsigned sample
sample_ready_o  out  1  sample accepted when valid & ready
host_wr_i  in  1  host write strobe; same signal that drives the register's wr2
data1_o  out  DATA_W  averaged value to the register's data1
wr1_o  out  1  one-cycle write strobe to the register's wr1
hold_ctrl_o  out  1  to the register's hold control
drop_cnt_o  out  8  saturating count of averages issued while hold was active

Behaviour:
- Reset (rst_ni=0, asynchronous): state=DISABLED, acc=0, cnt=0, data1_o=0, wr1_o=0, hold counter=0, hold_ctrl_o=0, drop_cnt_o=0, sample_ready_o=0.
- FSM states: DISABLED, ACCUM, WRITE.
- DISABLED: sample_ready_o=0. Moves to ACCUM on the cycle after enable_i=1, with acc=0 and cnt=0.
- ACCUM: sample_ready_o=1.
  - Each accepted sample: acc += sample, cnt += 1.
  - Accumulator width is DATA_W+AVG_LOG2, so it never overflows.
  - When the accepted sample is number 2^AVG_LOG2: load data1_o = (acc+sample) >> AVG_LOG2, go to WRITE.
- WRITE: lasts exactly one cycle.
  - wr1_o=1 and sample_ready_o=0.
  - Next state is ACCUM with acc=0 and cnt=0.
- Latency: wr1_o rises the cycle after the last sample of a group is accepted. Maximum throughput is one average per 2^AVG_LOG2+1 cycles.
- data1_o holds its value between writes.
- enable_i=0 in any state: next cycle goes to DISABLED, and acc/cnt are cleared (partial group discarded).
  - A WRITE already in progress completes its wr1_o pulse that cycle.
  - data1_o keeps its last value.
- AVG_LOG2=0: each accepted sample is written directly (ACCUM→WRITE every sample).
- Hold timer (independent of the FSM):
  - host_wr_i=1 loads the counter with HOLD_CYCLES. Otherwise the counter decrements if nonzero.
  - hold_ctrl_o = (counter≠0), registered.
  - It rises the cycle after host_wr_i and stays high HOLD_CYCLES cycles.
  - host_wr_i during an active hold reloads the counter to HOLD_CYCLES.
- Drop counter: increments when wr1_o=1 and hold_ctrl_o=1 in the same cycle, because the register ignores that write. It saturates at 255.
- host_wr_i in the same cycle as wr1_o: hold is not yet high, so the write is not counted. The register itself gives wr1 priority.
- sample_valid_i while ready=0: the sample is not consumed. The upstream source must hold it.

Optional Feature:
Macro ACQ_ROUND_EN.
- Defined: the average is rounded half-up: (sum + 2^(AVG_LOG2-1)) >> AVG_LOG2. No rounding is applied when AVG_LOG2=0.
- Undefined: the average is truncated (floor).
- The accumulator gets one extra bit when the macro is defined, so the rounding addend cannot overflow.

Decomposition:
- Package acq_pkg holds:
  - acq_state_e enum {DISABLED, ACCUM, WRITE}
  - DROP_CNT_W=8 constant
  - a function computing the accumulator width from DATA_W/AVG_LOG2
- One sub-module, acq_hold_timer: parameter HOLD_CYCLES; inputs clk_i, rst_ni, host_wr_i; output hold_o.

Test Plan:
1. Reset mid-ACCUM: deassert rst_ni after 2 samples → all outputs 0 immediately (asynchronously); after release, 4 new samples are needed for the next wr1_o.
2. AVG_LOG2=2, enable=1, samples 10,20,30,42 back-to-back → wr1_o single pulse one cycle after 42 accepted. data1_o=25 without ACQ_ROUND_EN, 26 with it. sample_ready_o=0 during that pulse.
3. Hold: host_wr_i pulse at cycle t → hold_ctrl_o high for cycles t+1..t+4. A second pulse at t+2 extends it through t+6.
4. Drop: host_wr_i, then complete a group so wr1_o lands while hold_ctrl_o=1 → drop_cnt_o 0→1. Force 300 such events → drop_cnt_o stays at 255.
5. Disable mid-group: 3 samples accepted, enable_i=0 → no wr1_o, data1_o unchanged. Re-enable with 4 samples of value 8 → data1_o=8.
6. Backpressure: sample_valid_i held high continuously → exactly one sample is accepted per ACCUM cycle, none during WRITE, and each group sum matches the reference model.
